// File: rtl/p2s_pkg.sv
// rtl/p2s_pkg.sv - shared parameters, ID width helper and channel ID type for the p2s arbiter slice
package p2s_pkg;

   localparam int N_DEF = 8;
   localparam int M_DEF = 4;

   // A single channel still needs a one-bit ID field.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   typedef logic [clog2_min1(M_DEF)-1:0] ch_id_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority picker, searches from last+1 with wrap
module rr_pick
   import p2s_pkg::*;
#(
   parameter int M = M_DEF,
   localparam int ID_W = clog2_min1(M)
) (
   input  logic [M-1:0]    req,
   input  logic [ID_W-1:0] last,
   output logic [ID_W-1:0] gnt_idx,
   output logic            any
);

   logic [ID_W-1:0] idx;

   always_comb begin
      gnt_idx = '0;
      any     = 1'b0;
      idx     = '0;
      for (int k = 1; k <= M; k++) begin
         idx = ID_W'((int'(last) + k) % M);
         if (!any && req[idx]) begin
            any     = 1'b1;
            gnt_idx = idx;
         end
      end
   end

endmodule

// File: rtl/p2s_arbiter.sv
// rtl/p2s_arbiter.sv - M-channel round-robin arbiter with burst lock feeding a shared p2s serializer
module p2s_arbiter
   import p2s_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int M     = M_DEF,
   parameter int BURST = 4,
   localparam int ID_W = clog2_min1(M)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [M-1:0]    ch_en,
   input  logic [M*N-1:0]  in_data,
   input  logic [M-1:0]    in_valid,
   output logic [M-1:0]    in_ready,
   output logic [N-1:0]    m_data,
   output logic [ID_W-1:0] m_id,
   output logic            m_valid,
   input  logic            m_ready,
   output logic            busy
);

   localparam int              CNT_W    = $clog2(BURST + 1);
   localparam logic [ID_W-1:0] LAST_RST = ID_W'(M - 1);

   logic [ID_W-1:0]  last;
   logic [ID_W-1:0]  owner;
   logic [ID_W-1:0]  pick_idx;
   logic [ID_W-1:0]  grant;
   logic [CNT_W-1:0] burst_cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             lock;
   logic             load;
   logic             pick_any;
   logic             cont;
   logic [M-1:0]     elig;
   logic [N-1:0]     word [M];

   assign load = !m_valid || m_ready;
   assign elig = in_valid & ch_en;
   assign busy = m_valid || lock;

   rr_pick #(.M(M)) u_pick (
      .req     (elig),
      .last    (last),
      .gnt_idx (pick_idx),
      .any     (pick_any)
   );

   // The burst only continues while the owner keeps offering; any gap re-enters rotation.
   always_comb begin
      cont     = lock && elig[owner];
      grant    = cont ? owner : pick_idx;
      cnt_nxt  = cont ? burst_cnt + CNT_W'(1) : CNT_W'(1);
      in_ready = '0;
      for (int i = 0; i < M; i++) begin
         word[i]     = in_data[i*N +: N];
         in_ready[i] = load && pick_any && !rst && (grant == ID_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid   <= 1'b0;
         m_data    <= '0;
         m_id      <= '0;
         last      <= LAST_RST;
         owner     <= '0;
         burst_cnt <= '0;
         lock      <= 1'b0;
      end else if (load) begin
         if (pick_any) begin
            m_data    <= word[grant];
            m_id      <= grant;
            m_valid   <= 1'b1;
            last      <= grant;
            owner     <= grant;
            burst_cnt <= cnt_nxt;
            lock      <= (cnt_nxt < CNT_W'(BURST));
         end else begin
            m_valid <= 1'b0;
            lock    <= 1'b0;
         end
      end else if (!ch_en[owner]) begin
         lock <= 1'b0;
      end
   end

endmodule

// File: tb/tb_p2s_arbiter.sv
// tb/tb_p2s_arbiter.sv - self-checking bench for p2s_arbiter (BURST=1 and BURST=4 instances)
module tb_p2s_arbiter;

   localparam int N = 8;
   localparam int M = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [M-1:0] ch_en = '1;
   logic [M-1:0] in_valid = '0;
   logic [M*N-1:0] in_data = '0;
   logic         m_ready = 1'b1;

   logic [M-1:0] rdy1, rdy4;
   logic [N-1:0] md1, md4;
   logic [1:0]   mid1, mid4;
   logic         mv1, mv4, busy1, busy4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int last;
      int owner;
      int cnt;
      bit lock;
      bit mv;
      int md;
      int mid;
   } mst_t;

   mst_t ms1, ms4;

   p2s_arbiter #(.N(N), .M(M), .BURST(1)) u_rr (
      .clk(clk), .rst(rst), .ch_en(ch_en), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy1), .m_data(md1), .m_id(mid1), .m_valid(mv1), .m_ready(m_ready), .busy(busy1)
   );

   p2s_arbiter #(.N(N), .M(M), .BURST(4)) u_bu (
      .clk(clk), .rst(rst), .ch_en(ch_en), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy4), .m_data(md4), .m_id(mid4), .m_valid(mv4), .m_ready(m_ready), .busy(busy4)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Reference model: which channel the arbitration rules pick and what the output stage holds.
   function automatic mst_t model_reset();
      mst_t s;
      s.last = M - 1; s.owner = 0; s.cnt = 0; s.lock = 0; s.mv = 0; s.md = 0; s.mid = 0;
      return s;
   endfunction

   function automatic int model_pick(mst_t s, logic [M-1:0] en, logic [M-1:0] v);
      logic [M-1:0] e;
      e = en & v;
      if (s.lock && e[s.owner]) return s.owner;
      for (int k = 1; k <= M; k++) begin
         if (e[(s.last + k) % M]) return (s.last + k) % M;
      end
      return -1;
   endfunction

   function automatic logic [M-1:0] model_ready(mst_t s, logic [M-1:0] en, logic [M-1:0] v, logic mr);
      int g;
      if (s.mv && !mr) return '0;
      g = model_pick(s, en, v);
      if (g < 0) return '0;
      return M'(1 << g);
   endfunction

   function automatic mst_t model_step(mst_t s, logic [M-1:0] en, logic [M-1:0] v,
                                       logic [M*N-1:0] d, logic mr, int burst);
      int g;
      mst_t r;
      r = s;
      g = model_pick(s, en, v);
      if (!s.mv || mr) begin
         if (g >= 0) begin
            r.md  = int'((d >> (N * g)) & 'hFF);
            r.mid = g;
            r.mv  = 1;
            if (s.lock && g == s.owner) r.cnt = s.cnt + 1;
            else begin r.owner = g; r.cnt = 1; end
            r.lock = (r.cnt < burst);
            r.last = g;
         end else begin
            r.mv = 0;
            r.lock = 0;
         end
      end else if (!en[s.owner]) begin
         r.lock = 0;
      end
      return r;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ms1 = model_reset();
      ms4 = model_reset();
   endtask

   task automatic test_reset();
      ch_en = 4'hF; in_valid = 4'hF; in_data = 32'h43322110; m_ready = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (mv1 !== 1'b0 || mv4 !== 1'b0) begin errors++; $display("FAIL reset_mvalid got=%b/%b exp=0/0", mv1, mv4); end
         checks++;
         if (rdy1 !== 4'h0 || rdy4 !== 4'h0) begin errors++; $display("FAIL reset_ready got=%b/%b exp=0000/0000", rdy1, rdy4); end
         checks++;
         if (md4 !== 8'h00 || mid4 !== 2'd0) begin errors++; $display("FAIL reset_data got=%h/%0d exp=00/0", md4, mid4); end
      end
      rst = 1'b0;
      #1;
      checks++;
      if (rdy4 !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b exp=0001", rdy4); end
      @(posedge clk); #1;
      checks++;
      if (mv4 !== 1'b1 || mid4 !== 2'd0 || md4 !== 8'h10) begin
         errors++; $display("FAIL reset_first_word got=v%b id%0d d%h exp=v1 id0 d10", mv4, mid4, md4);
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] dat [4];
      dat[0] = 8'h10; dat[1] = 8'h21; dat[2] = 8'h32; dat[3] = 8'h43;
      ch_en = 4'hF; in_valid = 4'hF; in_data = 32'h43322110; m_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         checks++;
         if (mv1 !== 1'b1 || mid1 !== 2'(i % 4) || md1 !== dat[i % 4]) begin
            errors++; $display("FAIL rr_seq cyc=%0d got=v%b id%0d d%h exp=v1 id%0d d%h", i, mv1, mid1, md1, i % 4, dat[i % 4]);
         end
      end
   endtask

   task automatic test_burst();
      int exp;
      ch_en = 4'hF; in_valid = 4'b0110; in_data = 32'h43322110; m_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         exp = ((i / 4) % 2 == 0) ? 1 : 2;
         checks++;
         if (mid4 !== 2'(exp) || md4 !== ((exp == 1) ? 8'h21 : 8'h32) || busy4 !== 1'b1) begin
            errors++; $display("FAIL burst_seq cyc=%0d got=id%0d d%h busy%b exp=id%0d busy1", i, mid4, md4, busy4, exp);
         end
      end
   endtask

   task automatic test_backpressure();
      int bits_left = 0;
      logic [7:0] sh = '0;
      logic [7:0] cur_md;
      logic [7:0] prev_md = '0;
      logic [M-1:0] drop_v = '0;
      bit prev_hold = 0;
      bit hs;
      bit sbits[$];
      int words[$];
      logic [15:0] exp_bits;
      ch_en = 4'hF; in_valid = 4'b1001; in_data = {8'd52, 8'd0, 8'd0, 8'd62}; m_ready = 1'b1;
      do_reset();
      for (int cyc = 0; cyc < 30; cyc++) begin
         in_valid = in_valid & ~drop_v;
         m_ready = (bits_left == 0);
         #1;
         if (cyc == 1) begin
            checks++;
            if (mv4 !== 1'b1 || md4 !== 8'd62) begin errors++; $display("FAIL bp_first got=v%b d%0d exp=v1 d62", mv4, md4); end
         end
         if (mv4 && !m_ready) begin
            checks++;
            if (rdy4 !== 4'h0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", cyc, rdy4); end
            if (prev_hold) begin
               checks++;
               if (md4 !== prev_md) begin errors++; $display("FAIL bp_hold cyc=%0d got=%0d exp=%0d", cyc, md4, prev_md); end
            end
         end
         drop_v = in_valid & rdy4;
         hs = mv4 && m_ready;
         cur_md = md4;
         prev_hold = mv4 && !m_ready;
         prev_md = cur_md;
         @(posedge clk);
         if (bits_left > 0) begin
            sbits.push_back(sh[0]);
            sh = sh >> 1;
            bits_left--;
         end
         if (hs) begin
            sh = cur_md;
            bits_left = 8;
            words.push_back(int'(cur_md));
         end
         @(negedge clk);
      end
      checks++;
      if (words.size() != 2 || words[0] != 62 || words[1] != 52) begin
         errors++; $display("FAIL bp_words got_n=%0d exp=62,52", words.size());
      end
      exp_bits = {8'd52, 8'd62};
      checks++;
      if (sbits.size() != 16) begin
         errors++; $display("FAIL bp_serial_len got=%0d exp=16", sbits.size());
      end else begin
         for (int b = 0; b < 16; b++) begin
            if (sbits[b] != exp_bits[b]) begin
               errors++; $display("FAIL bp_serial bit=%0d got=%0d exp=%0d", b, sbits[b], exp_bits[b]);
               break;
            end
         end
      end
   endtask

   task automatic test_enable_mask();
      int exp;
      ch_en = 4'b1010; in_valid = 4'hF; in_data = 32'h43322110; m_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         exp = ((i / 4) % 2 == 0) ? 1 : 3;
         checks++;
         if (mv4 !== 1'b1 || mid4 !== 2'(exp)) begin
            errors++; $display("FAIL mask_seq cyc=%0d got=v%b id%0d exp=v1 id%0d", i, mv4, mid4, exp);
         end
      end
      do_reset();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      ch_en = 4'b1000;
      #1;
      checks++;
      if (rdy4 !== 4'b1000) begin errors++; $display("FAIL mask_drop_ready got=%b exp=1000", rdy4); end
      @(posedge clk); #1;
      checks++;
      if (mid4 !== 2'd3 || md4 !== 8'h43) begin errors++; $display("FAIL mask_drop_id got=id%0d d%h exp=id3 d43", mid4, md4); end
   endtask

   task automatic test_reset_mid();
      ch_en = 4'hF; in_valid = 4'hF; in_data = 32'h43322110; m_ready = 1'b0;
      do_reset();
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (mv4 !== 1'b1 || mid4 !== 2'd0) begin errors++; $display("FAIL rmid_pre got=v%b id%0d exp=v1 id0", mv4, mid4); end
      rst = 1'b1;
      #1;
      checks++;
      if (rdy4 !== 4'h0) begin errors++; $display("FAIL rmid_ready got=%b exp=0000", rdy4); end
      @(posedge clk); #1;
      checks++;
      if (mv4 !== 1'b0) begin errors++; $display("FAIL rmid_drop got=%b exp=0", mv4); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (rdy4 !== 4'b0001) begin errors++; $display("FAIL rmid_restart got=%b exp=0001", rdy4); end
      @(posedge clk); #1;
      checks++;
      if (mv4 !== 1'b1 || mid4 !== 2'd0) begin errors++; $display("FAIL rmid_word got=v%b id%0d exp=v1 id0", mv4, mid4); end
   endtask

   task automatic test_random();
      logic [M-1:0] e1, e4;
      ch_en = 4'hF; in_valid = 4'h0; m_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         in_valid = 4'($urandom);
         ch_en    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
         in_data  = 32'($urandom);
         m_ready  = ($urandom_range(0, 3) != 0);
         #1;
         e1 = model_ready(ms1, ch_en, in_valid, m_ready);
         e4 = model_ready(ms4, ch_en, in_valid, m_ready);
         checks++;
         if (rdy1 !== e1) begin errors++; $display("FAIL rnd_ready_b1 cyc=%0d got=%b exp=%b", i, rdy1, e1); end
         checks++;
         if (rdy4 !== e4) begin errors++; $display("FAIL rnd_ready_b4 cyc=%0d got=%b exp=%b", i, rdy4, e4); end
         @(posedge clk);
         ms1 = model_step(ms1, ch_en, in_valid, in_data, m_ready, 1);
         ms4 = model_step(ms4, ch_en, in_valid, in_data, m_ready, 4);
         @(negedge clk);
         checks++;
         if (mv1 !== ms1.mv || mid1 !== 2'(ms1.mid) || md1 !== 8'(ms1.md) || busy1 !== (ms1.mv || ms1.lock)) begin
            errors++; $display("FAIL rnd_out_b1 cyc=%0d got=v%b id%0d d%h b%b exp=v%b id%0d d%h b%b",
                               i, mv1, mid1, md1, busy1, ms1.mv, ms1.mid, ms1.md[7:0], ms1.mv || ms1.lock);
         end
         checks++;
         if (mv4 !== ms4.mv || mid4 !== 2'(ms4.mid) || md4 !== 8'(ms4.md) || busy4 !== (ms4.mv || ms4.lock)) begin
            errors++; $display("FAIL rnd_out_b4 cyc=%0d got=v%b id%0d d%h b%b exp=v%b id%0d d%h b%b",
                               i, mv4, mid4, md4, busy4, ms4.mv, ms4.mid, ms4.md[7:0], ms4.mv || ms4.lock);
         end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_burst();
      test_backpressure();
      test_enable_mask();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
